// File: rtl/mips_pkg.sv
// Shared MIPS ISA-1 constants and types for the ID/EX issue stage and the ALU.
package mips_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned CTRL_W  = 4;
    localparam int unsigned RADDR_W = 5;

    // ALU operation codes, also decoded by the ALU itself
    typedef enum logic [CTRL_W-1:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_NOR = 4'b0011,
        ALU_OR  = 4'b0100,
        ALU_SLT = 4'b0101,
        ALU_BEQ = 4'b0110,
        ALU_BNE = 4'b0111
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;

    typedef enum logic {OpBReg = 1'b0, OpBImm = 1'b1} op_b_e;
    typedef enum logic {ExtSign = 1'b0, ExtZero = 1'b1} ext_e;
    typedef enum logic [1:0] {DestNone = 2'd0, DestRd = 2'd1, DestRt = 2'd2} dest_sel_e;

    typedef struct packed {
        alu_op_e   alu_ctrl;
        op_b_e     op_b;
        ext_e      ext;
        dest_sel_e dest_sel;
        logic      reg_write;
        logic      mem_read;
        logic      mem_write;
        logic      branch;
        logic      illegal;
        logic      rt_is_source;
    } dec_t;

    // EX-stage command register contents
    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    entr1;
        logic [XLEN-1:0]    entr2;
        alu_op_e            alu_ctrl;
        logic [XLEN-1:0]    store_data;
        logic [RADDR_W-1:0] dest_reg;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               branch;
        logic               illegal;
    } ex_cmd_t;

    // Bubble keeps the datapath fields and kills everything with a side effect
    function automatic ex_cmd_t make_bubble(ex_cmd_t c);
        ex_cmd_t b;
        b           = c;
        b.valid     = 1'b0;
        b.reg_write = 1'b0;
        b.mem_read  = 1'b0;
        b.mem_write = 1'b0;
        b.branch    = 1'b0;
        b.illegal   = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/id_ex_alu_issue_if.sv
// EX-stage command bundle from the issue stage (master) to the ALU (slave).
interface id_ex_alu_issue_if;
    import mips_pkg::*;

    logic               out_valid;
    logic [XLEN-1:0]    entr1;
    logic [XLEN-1:0]    entr2;
    logic [CTRL_W-1:0]  alu_ctrl;
    logic [XLEN-1:0]    store_data;
    logic [RADDR_W-1:0] dest_reg;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic               illegal;

    modport master (
        output out_valid, entr1, entr2, alu_ctrl, store_data, dest_reg,
               reg_write, mem_read, mem_write, branch, illegal
    );

    modport slave (
        input  out_valid, entr1, entr2, alu_ctrl, store_data, dest_reg,
               reg_write, mem_read, mem_write, branch, illegal
    );

endinterface

// File: rtl/alu_decode.sv
// Combinational ISA-1 decoder: opcode/funct -> ALU op, operand select and control flags.
module alu_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);

    // Decode opcode first, then funct for R-type
    always_comb begin
        dec.alu_ctrl     = ALU_ADD;
        dec.op_b         = OpBReg;
        dec.ext          = ExtSign;
        dec.dest_sel     = DestNone;
        dec.reg_write    = 1'b0;
        dec.mem_read     = 1'b0;
        dec.mem_write    = 1'b0;
        dec.branch       = 1'b0;
        dec.illegal      = 1'b0;
        dec.rt_is_source = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec.dest_sel     = DestRd;
                dec.reg_write    = 1'b1;
                dec.rt_is_source = 1'b1;
                case (funct)
                    F_ADD:   dec.alu_ctrl = ALU_ADD;
                    F_SUB:   dec.alu_ctrl = ALU_SUB;
                    F_AND:   dec.alu_ctrl = ALU_AND;
                    F_OR:    dec.alu_ctrl = ALU_OR;
                    F_NOR:   dec.alu_ctrl = ALU_NOR;
                    F_SLT:   dec.alu_ctrl = ALU_SLT;
                    default: dec.illegal  = 1'b1;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
                dec.op_b      = OpBImm;
                dec.dest_sel  = DestRt;
                dec.reg_write = 1'b1;
                case (opcode)
                    OP_SLTI: dec.alu_ctrl = ALU_SLT;
                    OP_ANDI: begin
                        dec.alu_ctrl = ALU_AND;
                        dec.ext      = ExtZero;
                    end
                    OP_ORI: begin
                        dec.alu_ctrl = ALU_OR;
                        dec.ext      = ExtZero;
                    end
                    default: dec.alu_ctrl = ALU_ADD;
                endcase
            end
            OP_LW: begin
                dec.op_b      = OpBImm;
                dec.dest_sel  = DestRt;
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
            end
            OP_SW: begin
                dec.op_b         = OpBImm;
                dec.mem_write    = 1'b1;
                dec.rt_is_source = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec.alu_ctrl     = (opcode == OP_BEQ) ? ALU_BEQ : ALU_BNE;
                dec.branch       = 1'b1;
                dec.rt_is_source = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX issue stage: decode, operand select, load-use hazard detect and EX command register.
module id_ex_alu_issue
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [31:0]       instr,
    input  logic [XLEN-1:0]   rs_data,
    input  logic [XLEN-1:0]   rt_data,
    input  logic              stall_in,
    input  logic              flush,
    output logic              stall_if_id,
    id_ex_alu_issue_if.master ex
);

    dec_t               dec;
    ex_cmd_t            ex_q;
    ex_cmd_t            ex_d;
    logic [RADDR_W-1:0] rs_addr;
    logic [RADDR_W-1:0] rt_addr;
    logic [RADDR_W-1:0] rd_addr;
    logic [15:0]        imm;
    logic [XLEN-1:0]    imm_ext;
    logic [RADDR_W-1:0] dest_addr;
    logic               hazard;

    assign rs_addr = instr[25:21];
    assign rt_addr = instr[20:16];
    assign rd_addr = instr[15:11];
    assign imm     = instr[15:0];

    alu_decode u_alu_decode (
        .opcode (instr[31:26]),
        .funct  (instr[5:0]),
        .dec    (dec)
    );

    // Immediate extension and write-back register select
    always_comb begin
        imm_ext = (dec.ext == ExtZero) ? {{(XLEN-16){1'b0}}, imm} : {{(XLEN-16){imm[15]}}, imm};
        case (dec.dest_sel)
            DestRd:  dest_addr = rd_addr;
            DestRt:  dest_addr = rt_addr;
            default: dest_addr = '0;
        endcase
    end

    // Load in EX whose result is needed by the instruction in ID; $0 never hazards
    assign hazard = ex_q.valid && ex_q.mem_read && (ex_q.dest_reg != '0) &&
                    ((rs_addr == ex_q.dest_reg) ||
                     (dec.rt_is_source && (rt_addr == ex_q.dest_reg)));

    // Next EX command in priority order: flush, stall_in, hazard, issue, idle
    always_comb begin
        ex_d        = ex_q;
        stall_if_id = 1'b0;
        if (flush) begin
            ex_d = make_bubble(ex_q);
        end else if (stall_in) begin
            stall_if_id = 1'b1;
        end else if (hazard) begin
            stall_if_id = 1'b1;
            ex_d        = make_bubble(ex_q);
        end else if (in_valid) begin
            if (dec.illegal) begin
                ex_d         = make_bubble(ex_q);
                ex_d.illegal = 1'b1;
            end else begin
                ex_d.valid      = 1'b1;
                ex_d.entr1      = rs_data;
                ex_d.entr2      = (dec.op_b == OpBImm) ? imm_ext : rt_data;
                ex_d.alu_ctrl   = dec.alu_ctrl;
                ex_d.store_data = rt_data;
                ex_d.dest_reg   = dest_addr;
                ex_d.reg_write  = dec.reg_write && (dest_addr != '0);
                ex_d.mem_read   = dec.mem_read;
                ex_d.mem_write  = dec.mem_write;
                ex_d.branch     = dec.branch;
                ex_d.illegal    = 1'b0;
            end
        end else begin
            ex_d = make_bubble(ex_q);
        end
    end

    // EX command register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex.out_valid  = ex_q.valid;
    assign ex.entr1      = ex_q.entr1;
    assign ex.entr2      = ex_q.entr2;
    assign ex.alu_ctrl   = ex_q.alu_ctrl;
    assign ex.store_data = ex_q.store_data;
    assign ex.dest_reg   = ex_q.dest_reg;
    assign ex.reg_write  = ex_q.reg_write;
    assign ex.mem_read   = ex_q.mem_read;
    assign ex.mem_write  = ex_q.mem_write;
    assign ex.branch     = ex_q.branch;
    assign ex.illegal    = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed bench for the ID/EX issue stage with hand-computed expectations.
module tb_id_ex_alu_issue;
    import mips_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        stall_in;
    logic        flush;
    logic        stall_if_id;

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_alu_issue_if ex_if ();

    id_ex_alu_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .instr       (instr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .stall_in    (stall_in),
        .flush       (flush),
        .stall_if_id (stall_if_id),
        .ex          (ex_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input logic [5:0] fn);
        logic [4:0] a, b, d;
        a = rs[4:0];
        b = rt[4:0];
        d = rd[4:0];
        return {OP_RTYPE, a, b, d, 5'b0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        logic [4:0] a, b;
        a = rs[4:0];
        b = rt[4:0];
        return {op, a, b, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] rsd, input logic [31:0] rtd);
        in_valid = 1'b1;
        instr    = ins;
        rs_data  = rsd;
        rt_data  = rtd;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        instr    = '0;
        rs_data  = '0;
        rt_data  = '0;
        stall_in = 1'b0;
        flush    = 1'b0;
        #1;
        check_eq("rst_valid", ex_if.out_valid, 0);
        check_eq("rst_alu", ex_if.alu_ctrl, 0);
        check_eq("rst_illegal", ex_if.illegal, 0);
        repeat (2) step();
        rst_n = 1'b1;

        // add $3,$1,$2
        drive(rtype(1, 2, 3, F_ADD), 5, 7);
        step();
        check_eq("add_valid", ex_if.out_valid, 1);
        check_eq("add_alu", ex_if.alu_ctrl, 4'b0000);
        check_eq("add_e1", ex_if.entr1, 5);
        check_eq("add_e2", ex_if.entr2, 7);
        check_eq("add_dest", ex_if.dest_reg, 3);
        check_eq("add_rw", ex_if.reg_write, 1);

        // Extension
        drive(itype(OP_ADDI, 9, 4, 16'hFFFF), 10, 99);
        step();
        check_eq("addi_e2", ex_if.entr2, 32'hFFFF_FFFF);
        check_eq("addi_e1", ex_if.entr1, 10);
        check_eq("addi_dest", ex_if.dest_reg, 4);
        drive(itype(OP_ORI, 9, 4, 16'hFFFF), 10, 99);
        step();
        check_eq("ori_e2", ex_if.entr2, 32'h0000_FFFF);
        check_eq("ori_alu", ex_if.alu_ctrl, 4'b0100);

        // Load-use: lw $4 then sub $5,$4,$6
        drive(itype(OP_LW, 8, 4, 16'h0010), 100, 0);
        step();
        check_eq("lw_mr", ex_if.mem_read, 1);
        check_eq("lw_dest", ex_if.dest_reg, 4);
        drive(rtype(4, 6, 5, F_SUB), 11, 22);
        #1;
        check_eq("lu_stall", stall_if_id, 1);
        step();
        check_eq("lu_bubble", ex_if.out_valid, 0);
        check_eq("lu_bubble_rw", ex_if.reg_write, 0);
        check_eq("lu_stall_clr", stall_if_id, 0);
        step();
        check_eq("lu_issue_valid", ex_if.out_valid, 1);
        check_eq("lu_issue_alu", ex_if.alu_ctrl, 4'b0001);
        check_eq("lu_issue_dest", ex_if.dest_reg, 5);

        // lw $0 never hazards and never writes
        drive(itype(OP_LW, 8, 0, 16'h0000), 100, 0);
        step();
        check_eq("lw0_rw", ex_if.reg_write, 0);
        drive(rtype(0, 6, 5, F_SUB), 0, 22);
        #1;
        check_eq("lw0_nostall", stall_if_id, 0);
        step();
        check_eq("lw0_issue", ex_if.out_valid, 1);

        // lw $4 then sw $4,4($8): rt is a source
        drive(itype(OP_LW, 8, 4, 16'h0000), 100, 0);
        step();
        drive(itype(OP_SW, 8, 4, 16'h0004), 200, 77);
        #1;
        check_eq("sw_stall", stall_if_id, 1);
        step();
        check_eq("sw_bubble", ex_if.out_valid, 0);
        step();
        check_eq("sw_valid", ex_if.out_valid, 1);
        check_eq("sw_mw", ex_if.mem_write, 1);
        check_eq("sw_sdata", ex_if.store_data, 77);
        check_eq("sw_e2", ex_if.entr2, 4);
        check_eq("sw_rw", ex_if.reg_write, 0);

        // lw $4 then addi $4,$9,1: rt is only a destination
        drive(itype(OP_LW, 8, 4, 16'h0000), 100, 0);
        step();
        drive(itype(OP_ADDI, 9, 4, 16'h0001), 3, 0);
        #1;
        check_eq("addi_nostall", stall_if_id, 0);
        step();
        check_eq("addi_issue", ex_if.out_valid, 1);

        // stall_in holds the EX register
        drive(rtype(1, 2, 3, F_AND), 32'hF0, 32'h3C);
        step();
        check_eq("and_alu", ex_if.alu_ctrl, 4'b0010);
        stall_in = 1'b1;
        drive(rtype(1, 2, 7, F_SUB), 1, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("hold_valid", ex_if.out_valid, 1);
            check_eq("hold_alu", ex_if.alu_ctrl, 4'b0010);
            check_eq("hold_e1", ex_if.entr1, 32'hF0);
            check_eq("hold_dest", ex_if.dest_reg, 3);
            check_eq("hold_stall", stall_if_id, 1);
        end
        flush = 1'b1;
        #1;
        check_eq("flush_stall_clr", stall_if_id, 0);
        step();
        check_eq("flush_over_stall", ex_if.out_valid, 0);
        flush    = 1'b0;
        stall_in = 1'b0;

        // Flush during a hazard
        drive(itype(OP_LW, 8, 4, 16'h0000), 100, 0);
        step();
        flush = 1'b1;
        drive(rtype(4, 6, 5, F_SUB), 11, 22);
        #1;
        check_eq("flush_hz_stall", stall_if_id, 0);
        step();
        check_eq("flush_hz_valid", ex_if.out_valid, 0);
        check_eq("flush_hz_mr", ex_if.mem_read, 0);
        flush = 1'b0;

        // Decode coverage
        drive(itype(OP_BEQ, 1, 2, 16'h0008), 3, 3);
        step();
        check_eq("beq_alu", ex_if.alu_ctrl, 4'b0110);
        check_eq("beq_br", ex_if.branch, 1);
        check_eq("beq_rw", ex_if.reg_write, 0);
        check_eq("beq_e2", ex_if.entr2, 3);
        drive(itype(OP_BNE, 1, 2, 16'h0008), 3, 4);
        step();
        check_eq("bne_alu", ex_if.alu_ctrl, 4'b0111);
        drive(rtype(1, 2, 9, F_SLT), 1, 2);
        step();
        check_eq("slt_alu", ex_if.alu_ctrl, 4'b0101);
        check_eq("slt_rw", ex_if.reg_write, 1);
        drive(itype(OP_SLTI, 1, 9, 16'h8000), 1, 2);
        step();
        check_eq("slti_alu", ex_if.alu_ctrl, 4'b0101);
        check_eq("slti_e2", ex_if.entr2, 32'hFFFF_8000);
        drive(rtype(1, 2, 9, F_NOR), 1, 2);
        step();
        check_eq("nor_alu", ex_if.alu_ctrl, 4'b0011);
        drive(32'hFC00_0000, 1, 2);
        step();
        check_eq("ill_flag", ex_if.illegal, 1);
        check_eq("ill_valid", ex_if.out_valid, 0);
        check_eq("ill_rw", ex_if.reg_write, 0);

        // Reset during stall_in
        drive(rtype(1, 2, 3, F_ADD), 5, 7);
        step();
        check_eq("legal_after_ill", ex_if.illegal, 0);
        stall_in = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        check_eq("rst_stall_valid", ex_if.out_valid, 0);
        check_eq("rst_stall_e1", ex_if.entr1, 0);
        check_eq("rst_stall_dest", ex_if.dest_reg, 0);
        step();
        rst_n    = 1'b1;
        stall_in = 1'b0;
        step();
        check_eq("post_rst_issue", ex_if.out_valid, 1);
        check_eq("post_rst_e1", ex_if.entr1, 5);

        // Reset during a hazard
        drive(itype(OP_LW, 8, 4, 16'h0000), 100, 0);
        step();
        drive(rtype(4, 6, 5, F_SUB), 11, 22);
        #1;
        check_eq("hz_pre_rst", stall_if_id, 1);
        rst_n = 1'b0;
        #1;
        check_eq("hz_rst_stall", stall_if_id, 0);
        check_eq("hz_rst_mr", ex_if.mem_read, 0);
        step();
        rst_n = 1'b1;
        step();
        check_eq("hz_rst_issue", ex_if.out_valid, 1);
        check_eq("hz_rst_alu", ex_if.alu_ctrl, 4'b0001);

        in_valid = 1'b0;
        step();
        check_eq("idle_bubble", ex_if.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
